// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode constants, IR field
// layout, sequencer states and the opcode classification / ALU-code helpers.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  // Upper 17 bits of IR; the low 15 bits are not used by this sequencer.
  typedef struct packed {
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } ir_fields_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU;
      OP_DIV, OP_MUL:                 cls = CLS_MULDIV;
      OP_NOP:                         cls = CLS_NOP;
      OP_HALT:                        cls = CLS_HALT;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // The ALU select code equals the opcode for every op that reaches the ALU.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    op_class_t cls;
    cls = classify(op);
    return (cls == CLS_ALU || cls == CLS_MULDIV) ? op : 5'd0;
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-to-16 one-hot decoder with enable; drives register load/drive strobes.
module reg_decoder_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T0-T6 sequencer: fetches through MAR/MDR, decodes IR and emits
// Moore-style datapath strobes for ALU, MUL/DIV, NOP and HALT instructions.
module control_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        stop,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        incPC,
  output logic        MARin,
  output logic        read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        running,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instr_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t             state, next_state;
  ir_fields_t         f;
  op_class_t          cls;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               retire, set_illegal, set_bus_err;
  logic               rin_en, rout_en;
  logic [3:0]         rout_sel;
  logic               unused_ir_low;

  assign f             = ir[31:15];
  assign cls           = classify(f.op);
  assign unused_ir_low = ^ir[14:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      S_IDLE, S_HALT: if (run && !stop) next_state = S_T0;
      S_T0: next_state = S_T1;
      S_T1: begin
        if (mem_ready) begin
          next_state = S_T2;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          next_state  = S_HALT;
          set_bus_err = 1'b1;
        end
      end
      S_T2: next_state = S_T3;
      S_T3: begin
        case (cls)
          CLS_NOP: begin
            retire     = 1'b1;
            next_state = stop ? S_HALT : S_T0;
          end
          CLS_HALT: begin
            retire     = 1'b1;
            next_state = S_HALT;
          end
          CLS_ILLEGAL: begin
            set_illegal = 1'b1;
            next_state  = S_HALT;
          end
          default: next_state = S_T4;
        endcase
      end
      S_T4: next_state = S_T5;
      S_T5: begin
        if (cls == CLS_MULDIV) begin
          next_state = S_T6;
        end else begin
          retire     = 1'b1;
          next_state = stop ? S_HALT : S_T0;
        end
      end
      S_T6: begin
        retire     = 1'b1;
        next_state = stop ? S_HALT : S_T0;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = 5'd0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = f.rb;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
      end
      S_T1: begin
        read  = 1'b1;
        MDRin = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls == CLS_ALU || cls == CLS_MULDIV) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_sel = f.rc;
        Zin      = 1'b1;
        opcode   = alu_code(f.op);
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (cls == CLS_MULDIV) LOin   = 1'b1;
        else                   rin_en = 1'b1;
      end
      S_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign running = (state == S_T0) || (state == S_T1) || (state == S_T2) ||
                   (state == S_T3) || (state == S_T4) || (state == S_T5) ||
                   (state == S_T6);
  assign halted  = (state == S_HALT);

  reg_decoder_4to16 u_rin_dec (
    .sel    (f.ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_decoder_4to16 u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      // Counts cycles spent in T1; zero on every T1 entry.
      wait_cnt <= (state == S_T1) ? wait_cnt + WAIT_W'(1) : '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (retire)      instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, random
// instructions against a per-instruction summary model, and reset corner cases.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, run, stop, mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic        PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin;
  logic        ZLowOut, ZHighOut, HIin, LOin;
  logic [4:0]  opcode;
  logic        running, halted, illegal, bus_err;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.TIMEOUT(16)) dut (
    .clock(clock), .clear(clear), .run(run), .stop(stop), .mem_ready(mem_ready),
    .ir(ir), .Rin(Rin), .Rout(Rout), .PCout(PCout), .incPC(incPC), .MARin(MARin),
    .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
    .opcode(opcode), .running(running), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // One instruction: stimulus plus its summarised observable effect.
  typedef struct {
    string       name;
    logic [31:0] ir;
    int          delay;     // T1 cycles before mem_ready rises
    int          stop_at;   // cycle index from which stop is held high, -1 = never
    int          cycles;    // cycles from T0 until back in T0 or HALT
    logic [15:0] rin;       // OR of Rin over the instruction
    logic [15:0] rout;      // OR of Rout over the instruction
    logic [4:0]  opc;       // OR of opcode over the instruction
    int          reads, mdrin, lo, hi, retired;
    bit          halts;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'h0};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, input int d, input int s,
                              input int cyc, input logic [15:0] rin, input logic [15:0] rout,
                              input logic [4:0] opc, input int reads, input int mdrin,
                              input int lo, input int hi, input int ret, input bit halts);
    vec_t v;
    v.name = n; v.ir = i; v.delay = d; v.stop_at = s; v.cycles = cyc;
    v.rin = rin; v.rout = rout; v.opc = opc; v.reads = reads; v.mdrin = mdrin;
    v.lo = lo; v.hi = hi; v.retired = ret; v.halts = halts;
    return v;
  endfunction

  // Reference: what one instruction should do overall, from the opcode table alone.
  function automatic vec_t model(input string n, input logic [31:0] i, input int d, input int s);
    vec_t v;
    logic [4:0] op;
    bit alu, md, nop, hlt, ill;
    op  = i[31:27];
    alu = (op >= 5'd3 && op <= 5'd10);
    md  = (op == 5'd15 || op == 5'd16);
    nop = (op == 5'd26);
    hlt = (op == 5'd27);
    ill = !(alu || md || nop || hlt);
    v.name = n; v.ir = i; v.delay = d; v.stop_at = s;
    v.cycles  = (alu ? 6 : md ? 7 : 4) + d;
    v.rin     = alu ? (16'h1 << i[26:23]) : 16'h0;
    v.rout    = (alu || md) ? ((16'h1 << i[22:19]) | (16'h1 << i[18:15])) : 16'h0;
    v.opc     = (alu || md) ? op : 5'd0;
    v.reads   = d + 1;
    v.mdrin   = 1;
    v.lo      = md ? 1 : 0;
    v.hi      = md ? 1 : 0;
    v.retired = ill ? 0 : 1;
    v.halts   = ill || hlt || (s >= 0 && s <= v.cycles - 1);
    return v;
  endfunction

  task automatic enter_t0(input string name);
    if (!PCout) begin
      run  = 1'b1;
      stop = 1'b0;
      #1;
      @(posedge clock); #1;
    end
    check({name, "_enter_t0"}, PCout, 1);
  endtask

  // Runs one instruction starting in T0 and accumulates what the strobes did.
  task automatic run_vec(input vec_t v, output vec_t o);
    logic [31:0] ic0;
    int multi;
    bit done;
    o = v;
    o.cycles = 0; o.rin = '0; o.rout = '0; o.opc = '0;
    o.reads = 0; o.mdrin = 0; o.lo = 0; o.hi = 0;
    ic0   = instr_count;
    multi = 0;
    done  = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      ir        = v.ir;
      mem_ready = (c >= 1 + v.delay);
      stop      = (v.stop_at >= 0 && c >= v.stop_at);
      run       = 1'b1;
      #1;
      o.rin  |= Rin;
      o.rout |= Rout;
      o.opc  |= opcode;
      o.reads += int'(read);
      o.mdrin += int'(MDRin);
      o.lo    += int'(LOin);
      o.hi    += int'(HIin);
      if ($countones(Rin) > 1 || $countones(Rout) > 1) multi++;
      @(posedge clock); #1;
      o.cycles = c + 1;
      if (PCout || halted) done = 1'b1;
    end
    check({v.name, "_finished"}, 32'(done), 1);
    check({v.name, "_onehot"}, multi, 0);
    o.retired = int'(instr_count - ic0);
    o.halts   = halted;
  endtask

  task automatic compare(input vec_t e, input vec_t g);
    check({e.name, "_cycles"},  g.cycles,  e.cycles);
    check({e.name, "_rin"},     g.rin,     e.rin);
    check({e.name, "_rout"},    g.rout,    e.rout);
    check({e.name, "_opcode"},  g.opc,     e.opc);
    check({e.name, "_reads"},   g.reads,   e.reads);
    check({e.name, "_mdrin"},   g.mdrin,   e.mdrin);
    check({e.name, "_lo_hi"},   {g.lo[15:0], g.hi[15:0]}, {e.lo[15:0], e.hi[15:0]});
    check({e.name, "_retired"}, g.retired, e.retired);
    check({e.name, "_halted"},  32'(g.halts), 32'(e.halts));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rin_rout"}, {Rin, Rout}, 32'h0);
    check({name, "_strobes"}, {PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin,
                               ZLowOut, ZHighOut, HIin, LOin}, 32'h0);
    check({name, "_status"}, {opcode, running, halted, illegal, bus_err}, 32'h0);
    check({name, "_count"}, instr_count, 32'h0);
  endtask

  vec_t tbl[10];
  vec_t got, exp_v;

  initial begin
    clear = 1'b1; run = 1'b0; stop = 1'b0; mem_ready = 1'b0; ir = '0;

    tbl[0] = mk("add",        mkir(5'd3,  4'd4, 4'd3, 4'd7),  0, -1,  6, 16'h0010, 16'h0088, 5'd3,  1, 1, 0, 0, 1, 0);
    tbl[1] = mk("mul",        mkir(5'd16, 4'd1, 4'd2, 4'd6),  0, -1,  7, 16'h0000, 16'h0044, 5'd16, 1, 1, 1, 1, 1, 0);
    tbl[2] = mk("add_wait3",  mkir(5'd3,  4'd4, 4'd3, 4'd7),  3, -1,  9, 16'h0010, 16'h0088, 5'd3,  4, 1, 0, 0, 1, 0);
    tbl[3] = mk("timeout",    mkir(5'd3,  4'd4, 4'd3, 4'd7), 99, -1, 17, 16'h0000, 16'h0000, 5'd0, 16, 0, 0, 0, 0, 1);
    tbl[4] = mk("nop",        mkir(5'd26, 4'd2, 4'd2, 4'd2),  0, -1,  4, 16'h0000, 16'h0000, 5'd0,  1, 1, 0, 0, 1, 0);
    tbl[5] = mk("illegal",    mkir(5'd31, 4'd5, 4'd6, 4'd7),  0, -1,  4, 16'h0000, 16'h0000, 5'd0,  1, 1, 0, 0, 0, 1);
    tbl[6] = mk("halt_op",    mkir(5'd27, 4'd0, 4'd0, 4'd0),  0, -1,  4, 16'h0000, 16'h0000, 5'd0,  1, 1, 0, 0, 1, 1);
    tbl[7] = mk("add_stop",   mkir(5'd3,  4'd4, 4'd3, 4'd7),  0,  4,  6, 16'h0010, 16'h0088, 5'd3,  1, 1, 0, 0, 1, 1);
    tbl[8] = mk("div_r0",     mkir(5'd15, 4'd0, 4'd9, 4'd15), 1, -1,  8, 16'h0000, 16'h8200, 5'd15, 2, 1, 1, 1, 1, 0);
    tbl[9] = mk("shl_r0",     mkir(5'd8,  4'd0, 4'd1, 4'd1),  0, -1,  6, 16'h0001, 16'h0002, 5'd8,  1, 1, 0, 0, 1, 0);

    // Reset state while clear is held.
    #12;
    check_all_zero("reset");
    @(posedge clock); #1;
    clear = 1'b0;
    #1;
    @(posedge clock); #1;
    check("idle_without_run", {running, halted}, 32'h0);

    // Directed table.
    foreach (tbl[k]) begin
      enter_t0(tbl[k].name);
      run_vec(tbl[k], got);
      compare(tbl[k], got);
    end
    check("sticky_illegal", illegal, 1);
    check("sticky_bus_err", bus_err, 1);

    // Random instructions against the model.
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      int r, d, s;
      int alu_ops[10] = '{3, 4, 5, 6, 7, 8, 9, 10, 15, 16};
      r = int'($urandom_range(0, 19));
      if (r < 12)       op = 5'(alu_ops[r % 10]);
      else if (r < 14)  op = 5'd26;
      else if (r == 14) op = 5'd27;
      else              op = 5'($urandom_range(0, 31));
      d = int'($urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      exp_v = model($sformatf("rnd%0d", n),
                    {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)}, d, s);
      enter_t0(exp_v.name);
      run_vec(exp_v, got);
      compare(exp_v, got);
    end

    // clear pulsed in T4 of an ADD: immediate return to IDLE, no retire.
    enter_t0("clr");
    ir = mkir(5'd3, 4'd4, 4'd3, 4'd7);
    mem_ready = 1'b1;
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
    end
    check("clr_in_t4", {Zin, opcode}, {1'b1, 5'd3});
    #1 clear = 1'b1;
    #1;
    check_all_zero("clr_async");
    @(posedge clock); #1;
    clear = 1'b0;
    run = 1'b0;
    #1;
    @(posedge clock); #1;
    check("clr_idle", {running, halted, 30'(instr_count)}, 32'h0);
    enter_t0("after_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer that drives the datapath's control strobes, sitting directly upstream of `datapath`. It fetches an instruction through the MAR/MDR path, latches it into IR, decodes the register fields, and steps through T0–T6. It replaces the hand-written control waveforms currently produced in datapath test benches. Scope: R-type ALU ops plus MUL/DIV (HI/LO results), NOP and HALT.

## Interface
- `TIMEOUT`, 16: maximum cycles T1 waits for `mem_ready` before flagging a bus error.
- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; leaves IDLE or HALT and starts fetching.
- `stop`  in  1  level; finish the current instruction, then HALT.
- `mem_ready`  in  1  memory data valid on `Mdatain` during T1.
- `ir`  in  32  datapath IR contents; valid from T3 onward.
- `Rin`  out  16  one-hot register load enables (R0–R15).
- `Rout`  out  16  one-hot register bus drives (R0–R15).
- `PCout`, `incPC`, `MARin`, `read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `ZLowOut`, `ZHighOut`, `HIin`, `LOin`  out  1 each  datapath strobes.
- `opcode`  out  5  ALU operation select.
- `running`  out  1  high in any T state.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; undefined opcode decoded.
- `bus_err`  out  1  sticky; `mem_ready` timeout.
- `instr_count`  out  32  retired-instruction counter.

Reset: `clock` single clock; `clear` is asynchronous, active-high. While `clear` is high, the state is IDLE and every output is 0, including the sticky flags and `instr_count`.

## Operation
- IR fields: op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- States: IDLE, T0–T6, HALT. Moore outputs are decoded from the state register and `ir`. Each strobe is high for exactly the cycle(s) of its state.
- IDLE: all strobes 0. Moves to T0 when `run && !stop`.
- T0: `PCout`, `MARin`, `incPC`.
- T1: `read` = 1 for the whole state; `MDRin` = `mem_ready`.
  - Advances to T2 in the cycle after `mem_ready` is seen.
  - The wait counter resets on entry. If it reaches `TIMEOUT` without `mem_ready`, set `bus_err` and go to HALT.
- T2: `MDRout`, `IRin`.
- T3: decode.
  - NOP: retire, then go to T0.
  - HALT op: retire, then go to HALT.
  - Undefined op: set `illegal`, go to HALT, do not retire.
  - Otherwise: `Rout[Rb]`, `Yin`.
- T4: `Rout[Rc]`, `Zin`, `opcode` = ALU code of the op.
- T5:
  - ALU op: `ZLowOut`, `Rin[Ra]`, retire.
  - MUL/DIV: `ZLowOut`, `LOin`.
- T6 (MUL/DIV only): `ZHighOut`, `HIin`, retire.
- Retire: `instr_count` += 1 (wraps at 2^32). Next state is HALT if `stop` is sampled high in the retire cycle, otherwise T0.
- HALT: all strobes 0, `halted` = 1. Moves to T0 on `run && !stop`; the sticky flags stay set.
- `stop` and `run` both high: `stop` wins.
- `opcode` is 0 outside T4. `Rin` and `Rout` are never multi-hot. Ra = R0 is allowed (no special case).

## Timing
- State register updates on the rising edge of `clock`. `clear` acts immediately and asynchronously, including mid-instruction, with no retire.
- With `mem_ready` high on T1 entry, T1 lasts 1 cycle.
  - ALU op: 6 cycles T0→T0.
  - MUL/DIV: 7 cycles.
  - NOP/HALT: 4 cycles.
- Each cycle of `mem_ready` delay adds one T1 cycle. `read` stays high throughout.
- `ir` is sampled combinationally from T3 onward. The datapath loads IR at the T2 edge.

## Structure
- Package `cpu_pkg` holds:
  - 5-bit op constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, DIV 01111, MUL 10000, NOP 11010, HALT 11011.
  - The ALU-code mapping (identity for ALU, MUL and DIV ops).
  - The state enum.
- One sub-module, `reg_decoder_4to16`, used twice for `Rin` and `Rout`, each with an enable input.

## Test plan
- ADD with ir = {00011, Ra=4, Rb=3, Rc=7}, `mem_ready` tied high → cycles T0..T5:
  - T3: `Rout` = 0x0008, `Yin`.
  - T4: `Rout` = 0x0080, `opcode` = 00011, `Zin`.
  - T5: `Rin` = 0x0010, `ZLowOut`.
  - `instr_count` = 1; back in T0 at cycle 6.
- MUL with Rb=2, Rc=6 → T5 `LOin`+`ZLowOut`, T6 `HIin`+`ZHighOut`; `Rin` stays 0 throughout; 7 cycles.
- `mem_ready` delayed 3 cycles → T1 held 4 cycles with `read` = 1 and `MDRin` pulsing only in the last cycle. A separate run with `mem_ready` never asserted and `TIMEOUT` = 16 → `bus_err` = 1 and `halted` = 1 after 16 T1 cycles.
- ir op = 11111 → `illegal` = 1, HALT after T3, `instr_count` unchanged.
- `stop` raised during T4 of an ADD → the ADD completes and retires, then HALT. Later `run` with `stop` = 0 → T0.
- `clear` pulsed during T4 → all outputs 0 immediately, state IDLE, `instr_count` = 0.
